// File: rtl/evt_frame_decoder.sv
// Address-event frame decoder: decodes {x, y, ts, pol} event words, bins ON/OFF counts per pixel over a time window, streams the frame out.
// Latency: an event lands in the counter array 1 cycle after valid_data_i; readout starts the cycle after the window closes.
// Backpressure: none on the event input (events arriving during readout are dropped and counted); the pixel port holds each word until pix_ready_i.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   valid_data_i, data_in_i   event word {x, y, ts, pol}; taken every valid cycle
//   flush_i                   close the open frame early (ignored when no frame is open)
//   pix_valid_o/pix_ready_i   pixel stream handshake; pix_addr_o={row,col}, pix_data_o={on_cnt,off_cnt}
//   frame_ts_o                start timestamp of the frame being read out
//   frame_done_o              1-cycle pulse after the last pixel handshake
//   drop_cnt_o                saturating count of dropped events
//   ts_err_o                  sticky out-of-order timestamp flag
//   busy_o                    high while the frame is being read out
module evt_frame_decoder #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int TS_W        = 16,
    parameter int CNT_W       = 4,
    parameter int FRAME_TICKS = 100,
    parameter int ROW_ADD     = $clog2(ROWS),
    parameter int COL_ADD     = $clog2(COLS),
    parameter int WIDTH       = ROW_ADD + COL_ADD + TS_W + 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_data_i,
    input  logic [WIDTH-1:0]           data_in_i,
    input  logic                       flush_i,
    input  logic                       pix_ready_i,
    output logic                       pix_valid_o,
    output logic [ROW_ADD+COL_ADD-1:0] pix_addr_o,
    output logic [2*CNT_W-1:0]         pix_data_o,
    output logic [TS_W-1:0]            frame_ts_o,
    output logic                       frame_done_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       ts_err_o,
    output logic                       busy_o
);

    localparam logic [ROW_ADD:0]   ROW_LIM  = (ROW_ADD + 1)'(ROWS);
    localparam logic [COL_ADD:0]   COL_LIM  = (COL_ADD + 1)'(COLS);
    localparam logic [ROW_ADD-1:0] LAST_ROW = ROW_ADD'(ROWS - 1);
    localparam logic [COL_ADD-1:0] LAST_COL = COL_ADD'(COLS - 1);
    localparam logic [TS_W-1:0]    FT       = TS_W'(FRAME_TICKS);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_READOUT
    } state_t;

    // ---------------- decode stage ----------------
    logic               ev_v_q;
    logic [ROW_ADD-1:0] ev_x_q;
    logic [COL_ADD-1:0] ev_y_q;
    logic [TS_W-1:0]    ev_ts_q;
    logic               ev_pol_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ev_v_q   <= 1'b0;
            ev_x_q   <= '0;
            ev_y_q   <= '0;
            ev_ts_q  <= '0;
            ev_pol_q <= 1'b0;
        end else begin
            ev_v_q <= valid_data_i;
            if (valid_data_i) begin
                ev_x_q   <= data_in_i[WIDTH-1 -: ROW_ADD];
                ev_y_q   <= data_in_i[WIDTH-1-ROW_ADD -: COL_ADD];
                ev_ts_q  <= data_in_i[TS_W:1];
                ev_pol_q <= data_in_i[0];
            end
        end
    end

    // ---------------- control state ----------------
    state_t             state_q;
    logic [TS_W-1:0]    frame_start_q;
    logic [TS_W-1:0]    last_ts_q;
    logic               pend_v_q;
    logic [ROW_ADD-1:0] pend_x_q;
    logic [COL_ADD-1:0] pend_y_q;
    logic [TS_W-1:0]    pend_ts_q;
    logic               pend_pol_q;
    logic [ROW_ADD-1:0] rd_row_q;
    logic [COL_ADD-1:0] rd_col_q;
    logic               pix_valid_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [15:0]        drop_cnt_q;
    logic               ts_err_q;

    logic [CNT_W-1:0] on_q  [ROWS][COLS];
    logic [CNT_W-1:0] off_q [ROWS][COLS];
    logic [CNT_W-1:0] on_d  [ROWS][COLS];
    logic [CNT_W-1:0] off_d [ROWS][COLS];

    logic               ev_in_range;
    logic               ev_ok;
    logic               ev_drop;
    logic               ev_in_win;
    logic [TS_W-1:0]    elapsed;
    logic [TS_W-1:0]    ts_step;
    logic               rd_hs;
    logic               rd_last;
    logic               acc_en;
    logic [ROW_ADD-1:0] acc_x;
    logic [COL_ADD-1:0] acc_y;
    logic               acc_pol;

    assign ev_in_range = ({1'b0, ev_x_q} < ROW_LIM) && ({1'b0, ev_y_q} < COL_LIM);
    assign ev_ok       = ev_v_q && ev_in_range && (state_q != S_READOUT);
    assign ev_drop     = ev_v_q && !(ev_in_range && (state_q != S_READOUT));
    // Modular differences make timestamp wrap transparent.
    assign elapsed     = ev_ts_q - frame_start_q;
    assign ts_step     = ev_ts_q - last_ts_q;
    assign ev_in_win   = elapsed < FT;
    assign rd_hs       = pix_valid_q && pix_ready_i;
    assign rd_last     = rd_hs && (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);

    // One accumulate port: either the decoded event or, at the end of readout,
    // the parked event that closed the previous window.
    always_comb begin
        acc_en  = 1'b0;
        acc_x   = ev_x_q;
        acc_y   = ev_y_q;
        acc_pol = ev_pol_q;
        if (state_q == S_READOUT) begin
            if (rd_last && pend_v_q) begin
                acc_en  = 1'b1;
                acc_x   = pend_x_q;
                acc_y   = pend_y_q;
                acc_pol = pend_pol_q;
            end
        end else if (ev_ok && ((state_q == S_IDLE) || ev_in_win)) begin
            acc_en = 1'b1;
        end
    end

    // Clear-on-read happens before the accumulate so a pending event that
    // targets the last pixel still leaves a count of 1 in the new frame.
    always_comb begin
        on_d  = on_q;
        off_d = off_q;
        if (rd_hs) begin
            on_d[rd_row_q][rd_col_q]  = '0;
            off_d[rd_row_q][rd_col_q] = '0;
        end
        if (acc_en) begin
            if (acc_pol) begin
                if (on_d[acc_x][acc_y] != CNT_MAX)
                    on_d[acc_x][acc_y] = on_d[acc_x][acc_y] + CNT_W'(1);
            end else begin
                if (off_d[acc_x][acc_y] != CNT_MAX)
                    off_d[acc_x][acc_y] = off_d[acc_x][acc_y] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    on_q[r][c]  <= '0;
                    off_q[r][c] <= '0;
                end
            end
        end else begin
            on_q  <= on_d;
            off_q <= off_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            frame_start_q <= '0;
            last_ts_q     <= '0;
            pend_v_q      <= 1'b0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            pend_ts_q     <= '0;
            pend_pol_q    <= 1'b0;
            rd_row_q      <= '0;
            rd_col_q      <= '0;
            pix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            drop_cnt_q    <= '0;
            ts_err_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (ev_drop && (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;

            // Out-of-order events are flagged but still processed normally.
            if (ev_ok) begin
                last_ts_q <= ev_ts_q;
                if (ts_step[TS_W-1])
                    ts_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (ev_ok) begin
                        frame_start_q <= ev_ts_q;
                        state_q       <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (ev_ok && !ev_in_win) begin
                        pend_v_q   <= 1'b1;
                        pend_x_q   <= ev_x_q;
                        pend_y_q   <= ev_y_q;
                        pend_ts_q  <= ev_ts_q;
                        pend_pol_q <= ev_pol_q;
                    end
                    if ((ev_ok && !ev_in_win) || flush_i) begin
                        state_q     <= S_READOUT;
                        pix_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_READOUT: begin
                    if (rd_hs) begin
                        if (rd_col_q == LAST_COL) begin
                            rd_col_q <= '0;
                            rd_row_q <= (rd_row_q == LAST_ROW) ? '0 : rd_row_q + ROW_ADD'(1);
                        end else begin
                            rd_col_q <= rd_col_q + COL_ADD'(1);
                        end
                    end
                    if (rd_last) begin
                        pix_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        pend_v_q     <= 1'b0;
                        if (pend_v_q) begin
                            frame_start_q <= pend_ts_q;
                            state_q       <= S_ACCUM;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_valid_o  = pix_valid_q;
    assign pix_addr_o   = {rd_row_q, rd_col_q};
    assign pix_data_o   = {on_q[rd_row_q][rd_col_q], off_q[rd_row_q][rd_col_q]};
    assign frame_ts_o   = frame_start_q;
    assign frame_done_o = frame_done_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign ts_err_o     = ts_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_evt_frame_decoder.sv
// Testbench for evt_frame_decoder: directed scenarios plus randomized event streams,
// checked against a frame-level reference model (per-pixel count arrays, window rules).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_evt_frame_decoder;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int NPIX  = ROWS * COLS;
    localparam int FT    = 100;
    localparam int WIDTH = 23;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             valid_data_i;
    logic [WIDTH-1:0] data_in_i;
    logic             flush_i;
    logic             pix_ready_i;
    logic             pix_valid_o;
    logic [5:0]       pix_addr_o;
    logic [7:0]       pix_data_o;
    logic [15:0]      frame_ts_o;
    logic             frame_done_o;
    logic [15:0]      drop_cnt_o;
    logic             ts_err_o;
    logic             busy_o;

    always #5 clk_i = ~clk_i;

    evt_frame_decoder dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_data_i (valid_data_i),
        .data_in_i    (data_in_i),
        .flush_i      (flush_i),
        .pix_ready_i  (pix_ready_i),
        .pix_valid_o  (pix_valid_o),
        .pix_addr_o   (pix_addr_o),
        .pix_data_o   (pix_data_o),
        .frame_ts_o   (frame_ts_o),
        .frame_done_o (frame_done_o),
        .drop_cnt_o   (drop_cnt_o),
        .ts_err_o     (ts_err_o),
        .busy_o       (busy_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what the next frame must contain and the status flags.
    int m_on  [NPIX];
    int m_off [NPIX];
    bit m_open;
    int m_start;
    int m_last;
    bit m_err;
    int m_drop;
    bit m_pend_v;
    int m_pend_idx;
    bit m_pend_pol;
    int m_pend_ts;

    logic [7:0] got [NPIX];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPIX; i++) begin
            m_on[i]  = 0;
            m_off[i] = 0;
        end
        m_open   = 0;
        m_start  = 0;
        m_last   = 0;
        m_err    = 0;
        m_drop   = 0;
        m_pend_v = 0;
    endtask

    task automatic model_add(input int idx, input bit pol);
        if (pol) m_on[idx]  = (m_on[idx]  < 15) ? m_on[idx]  + 1 : 15;
        else     m_off[idx] = (m_off[idx] < 15) ? m_off[idx] + 1 : 15;
    endtask

    function automatic logic [7:0] exp_pix(input int idx);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(m_on[idx]);
        b = 4'(m_off[idx]);
        return {a, b};
    endfunction

    // Returns close=1 when the event falls outside the open window.
    task automatic model_event(input int idx, input int ts, input bit pol, output bit close);
        close = 0;
        if (((ts - m_last) & 32'hFFFF) >= 32768) m_err = 1;
        m_last = ts;
        if (!m_open) begin
            m_open  = 1;
            m_start = ts;
            model_add(idx, pol);
        end else if (((ts - m_start) & 32'hFFFF) < FT) begin
            model_add(idx, pol);
        end else begin
            m_pend_v   = 1;
            m_pend_idx = idx;
            m_pend_pol = pol;
            m_pend_ts  = ts;
            close      = 1;
        end
    endtask

    // One event word; with_flush raises flush_i in the cycle the event is decoded.
    task automatic send_event(input logic [2:0] x, input logic [2:0] y, input logic [15:0] ts,
                              input logic pol, input bit with_flush, output bit close);
        bit was_open;
        was_open     = m_open;
        data_in_i    = {x, y, ts, pol};
        valid_data_i = 1'b1;
        tick();
        valid_data_i = 1'b0;
        model_event(int'(x) * COLS + int'(y), int'(ts), pol, close);
        if (with_flush) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            if (was_open) close = 1;
        end
    endtask

    task automatic do_flush(output bit fired);
        tick();
        fired   = m_open;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    // mode 0: plain readout with random stalls; 1: 10-cycle stall at pixel 20
    // with 3 injected events; 2: reset after 30 pixels.
    task automatic do_readout(input int mode);
        int         n        = 0;
        int         cyc      = 0;
        int         done_cnt = 0;
        bit         prev_stall = 0;
        logic [5:0] h_a = '0;
        logic [7:0] h_d = '0;
        while (!pix_valid_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ro_valid_up", pix_valid_o, 1);
        chk("ro_busy", busy_o, 1);
        chk("ro_frame_ts", frame_ts_o, m_start);
        while (n < NPIX && cyc < 3000) begin
            if (mode == 1 && n == 20) begin
                pix_ready_i = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    if (k == 1 || k == 3 || k == 5) begin
                        data_in_i    = {3'd5, 3'd5, 16'(m_last + 1), 1'b1};
                        valid_data_i = 1'b1;
                        m_drop++;
                    end
                    @(negedge clk_i);
                    chk("stall_addr", pix_addr_o, n);
                    chk("stall_data", pix_data_o, exp_pix(n));
                    chk("stall_busy", busy_o, 1);
                    tick();
                    valid_data_i = 1'b0;
                end
            end
            pix_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            if (frame_done_o) done_cnt++;
            chk("ro_valid", pix_valid_o, 1);
            if (prev_stall) begin
                chk("hold_addr", pix_addr_o, h_a);
                chk("hold_data", pix_data_o, h_d);
            end
            if (pix_ready_i) begin
                chk("ro_addr", pix_addr_o, n);
                chk("ro_data", pix_data_o, exp_pix(n));
                got[n]     = pix_data_o;
                n++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                h_a        = pix_addr_o;
                h_d        = pix_data_o;
            end
            tick();
            cyc++;
            if (mode == 2 && n == 30) begin
                pix_ready_i = 1'b0;
                reset_i     = 1'b1;
                @(negedge clk_i);
                chk("rst_valid", pix_valid_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_drop", drop_cnt_o, 0);
                chk("rst_done", frame_done_o, 0);
                tick();
                reset_i = 1'b0;
                model_reset();
                return;
            end
        end
        chk("ro_count", n, NPIX);
        pix_ready_i = 1'b0;
        @(negedge clk_i);
        chk("done_pulse", frame_done_o, 1);
        chk("valid_drop", pix_valid_o, 0);
        chk("busy_drop", busy_o, 0);
        chk("done_early", done_cnt, 0);
        tick();
        @(negedge clk_i);
        chk("done_once", frame_done_o, 0);
        tick();
        for (int i = 0; i < NPIX; i++) begin
            m_on[i]  = 0;
            m_off[i] = 0;
        end
        if (m_pend_v) begin
            m_start  = m_pend_ts;
            model_add(m_pend_idx, m_pend_pol);
            m_open   = 1;
            m_pend_v = 0;
        end else begin
            m_open = 0;
        end
        chk("drop_cnt", drop_cnt_o, m_drop);
        chk("ts_err", ts_err_o, m_err);
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        bit          cl;
        bit          fired;
        logic [15:0] ts_cur;
        logic [2:0]  rx;
        logic [2:0]  ry;
        reset_i      = 1'b1;
        valid_data_i = 1'b0;
        data_in_i    = '0;
        flush_i      = 1'b0;
        pix_ready_i  = 1'b0;
        model_reset();
        tick();
        @(negedge clk_i);
        chk("reset_valid", pix_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_addr", pix_addr_o, 0);
        chk("reset_data", pix_data_o, 0);
        chk("reset_fts", frame_ts_o, 0);
        chk("reset_done", frame_done_o, 0);
        chk("reset_drop", drop_cnt_o, 0);
        chk("reset_tserr", ts_err_o, 0);
        tick();
        reset_i = 1'b0;
        tick();

        // Mixed ON/OFF at one pixel, flush-closed frame.
        send_event(3'd2, 3'd3, 16'd10, 1'b1, 0, cl);
        send_event(3'd2, 3'd3, 16'd11, 1'b1, 0, cl);
        send_event(3'd2, 3'd3, 16'd12, 1'b1, 0, cl);
        send_event(3'd2, 3'd3, 16'd13, 1'b0, 0, cl);
        do_flush(fired);
        do_readout(0);
        chk("t1_pix13", got[19], 8'h31);

        // Saturation; the previous frame must have been cleared.
        for (int i = 0; i < 20; i++) send_event(3'd0, 3'd0, 16'(20 + i), 1'b1, 0, cl);
        do_flush(fired);
        do_readout(0);
        chk("t2_sat", got[0], 8'hF0);
        chk("t2_cleared", got[19], 8'h00);

        // Window close by timestamp, pending event opens the next frame.
        apply_reset();
        send_event(3'd1, 3'd1, 16'd5, 1'b1, 0, cl);
        send_event(3'd4, 3'd4, 16'd105, 1'b0, 0, cl);
        chk("t3_close", cl, 1);
        do_readout(0);
        chk("t3_f1_pix", got[9], 8'h10);
        chk("t3_f1_nopend", got[36], 8'h00);
        do_flush(fired);
        do_readout(0);
        chk("t3_f2_pend", got[36], 8'h01);

        // Long stall with events injected during readout.
        send_event(3'd3, 3'd3, 16'd200, 1'b1, 0, cl);
        do_flush(fired);
        do_readout(1);
        chk("t4_drops", drop_cnt_o, 3);
        send_event(3'd0, 3'd1, 16'd300, 1'b1, 0, cl);
        do_flush(fired);
        do_readout(0);
        chk("t4_not_in_frame", got[45], 8'h00);

        // Timestamp wrap inside a window, then an out-of-order event.
        apply_reset();
        send_event(3'd0, 3'd0, 16'd30000, 1'b1, 0, cl);
        do_flush(fired);
        do_readout(0);
        send_event(3'd0, 3'd0, 16'd60000, 1'b1, 0, cl);
        do_flush(fired);
        do_readout(0);
        send_event(3'd1, 3'd2, 16'd65530, 1'b1, 0, cl);
        send_event(3'd6, 3'd6, 16'd20, 1'b1, 0, cl);
        tick();
        tick();
        chk("t5_wrap_noerr", ts_err_o, 0);
        send_event(3'd7, 3'd0, 16'd10, 1'b0, 0, cl);
        tick();
        tick();
        chk("t5_ooo_err", ts_err_o, 1);
        do_flush(fired);
        do_readout(0);
        chk("t5_wrap_acc", got[54], 8'h10);
        chk("t5_sticky", ts_err_o, 1);

        // Reset in the middle of readout.
        for (int i = 0; i < 8; i++)
            send_event(3'(i), 3'(7 - i), 16'(100 + i), 1'b1, 0, cl);
        do_flush(fired);
        do_readout(2);
        send_event(3'd2, 3'd2, 16'd50, 1'b0, 0, cl);
        do_flush(fired);
        do_readout(0);
        chk("t6_clean_pix", got[18], 8'h01);
        chk("t6_clean_old", got[7], 8'h00);

        // Randomized streams.
        ts_cur = 16'd400;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)      ts_cur = ts_cur + 16'($urandom_range(150, 350));
            else if (r < 9) ts_cur = ts_cur - 16'($urandom_range(1, 50));
            else            ts_cur = ts_cur + 16'($urandom_range(0, 20));
            rx = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            ry = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            send_event(rx, ry, ts_cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), cl);
            if (cl) begin
                do_readout(0);
            end else if ($urandom_range(0, 39) == 0) begin
                do_flush(fired);
                if (fired) do_readout(0);
            end
        end
        do_flush(fired);
        if (fired) do_readout(0);
        chk("end_drop", drop_cnt_o, m_drop);
        chk("end_tserr", ts_err_o, m_err);
        chk("end_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
